// File: rtl/osc_freq_cal.sv
// Ring-oscillator frequency calibrator: counts osc edges per ref_clk window, runs a coarse
// thermometer search, a 5-bit fine SAR, then dead-band tracking of the captured target.
module osc_freq_cal #(
  parameter int CNT_W   = 12,
  parameter int WIN_CYC = 64,
  parameter int TOL     = 2
) (
  input  logic             ref_clk,
  input  logic             rstb,
  input  logic             cal_en,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic [CNT_W-1:0] osc_cnt_gray,
  output logic [7:0]       delay_con_msb,
  output logic [4:0]       delay_con_lsb,
  output logic             cal_busy,
  output logic             locked,
  output logic [CNT_W-1:0] meas_cnt
);
  localparam int WIN_W = $clog2(WIN_CYC);
  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, COARSE, FINE, TRACK} state_t;

  state_t           state_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] prev_reg;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] meas_reg;
  logic [7:0]       msb_reg;
  logic [4:0]       lsb_reg;
  logic [2:0]       bit_reg;
  logic             settle_reg;
  logic             busy_reg;
  logic             locked_reg;
  logic             cal_en_d_reg;

  logic [CNT_W-1:0] osc_bin;
  logic [CNT_W-1:0] delta;
  logic             win_end;
  logic             faster;
  logic             too_fast;
  logic             too_slow;
  logic [4:0]       bit_mask;
  logic [4:0]       fine_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_W; gi++) begin : g_gray2bin
      assign osc_bin[gi] = ^osc_cnt_gray[CNT_W-1:gi];
    end
  endgenerate

  // Modular subtraction keeps the delta correct across counter wrap.
  assign win_end  = (win_cnt_reg == WIN_W'(WIN_CYC - 1));
  assign delta    = osc_bin - prev_reg;
  assign faster   = (delta > target_reg);
  assign too_fast = ({1'b0, delta} > ({1'b0, target_reg} + TOL_W));
  assign too_slow = (({1'b0, delta} + TOL_W) < {1'b0, target_reg});

  // SAR step: drop the trial bit if the osc came out slow, then try the next lower bit.
  assign bit_mask = 5'd1 << bit_reg;
  assign fine_lsb = ((delta < target_reg) ? (lsb_reg & ~bit_mask) : lsb_reg) | (bit_mask >> 1);

  always_ff @(posedge ref_clk) begin
    if (!rstb) begin
      state_reg    <= IDLE;
      win_cnt_reg  <= '0;
      prev_reg     <= '0;
      target_reg   <= '0;
      meas_reg     <= '0;
      msb_reg      <= 8'h00;
      lsb_reg      <= 5'd0;
      bit_reg      <= 3'd0;
      settle_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      locked_reg   <= 1'b0;
      cal_en_d_reg <= 1'b1;
    end else begin
      cal_en_d_reg <= cal_en;
      win_cnt_reg  <= win_end ? '0 : win_cnt_reg + WIN_W'(1);
      if (win_end)
        prev_reg <= osc_bin;

      if (!cal_en) begin
        busy_reg   <= 1'b0;
        locked_reg <= 1'b0;
        if (state_reg != IDLE) begin
          state_reg   <= IDLE;
          win_cnt_reg <= '0;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (!cal_en_d_reg) begin
              target_reg  <= target_cnt;
              msb_reg     <= 8'h00;
              lsb_reg     <= 5'd0;
              busy_reg    <= 1'b1;
              locked_reg  <= 1'b0;
              settle_reg  <= 1'b1;
              win_cnt_reg <= '0;
              state_reg   <= COARSE;
            end
          end
          COARSE: begin
            if (win_end) begin
              if (settle_reg) begin
                settle_reg <= 1'b0;
              end else begin
                meas_reg   <= delta;
                settle_reg <= 1'b1;
                if (faster && msb_reg != 8'hFF) begin
                  msb_reg <= {msb_reg[6:0], 1'b1};
                end else begin
                  msb_reg   <= {1'b0, msb_reg[7:1]};
                  lsb_reg   <= 5'b10000;
                  bit_reg   <= 3'd4;
                  state_reg <= FINE;
                end
              end
            end
          end
          FINE: begin
            if (win_end) begin
              if (settle_reg) begin
                settle_reg <= 1'b0;
              end else begin
                meas_reg   <= delta;
                lsb_reg    <= fine_lsb;
                settle_reg <= (fine_lsb != lsb_reg);
                if (bit_reg != 3'd0) begin
                  bit_reg <= bit_reg - 3'd1;
                end else begin
                  busy_reg   <= 1'b0;
                  locked_reg <= 1'b1;
                  state_reg  <= TRACK;
                end
              end
            end
          end
          TRACK: begin
            if (win_end) begin
              if (settle_reg) begin
                settle_reg <= 1'b0;
              end else begin
                meas_reg <= delta;
                // A step past either end of the fine range means the coarse setting is stale.
                if ((too_fast && lsb_reg == 5'd31) || (too_slow && lsb_reg == 5'd0)) begin
                  msb_reg    <= 8'h00;
                  lsb_reg    <= 5'd0;
                  locked_reg <= 1'b0;
                  busy_reg   <= 1'b1;
                  settle_reg <= 1'b1;
                  state_reg  <= COARSE;
                end else if (too_fast) begin
                  lsb_reg    <= lsb_reg + 5'd1;
                  settle_reg <= 1'b1;
                end else if (too_slow) begin
                  lsb_reg    <= lsb_reg - 5'd1;
                  settle_reg <= 1'b1;
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign delay_con_msb = msb_reg;
  assign delay_con_lsb = lsb_reg;
  assign cal_busy      = busy_reg;
  assign locked        = locked_reg;
  assign meas_cnt      = meas_reg;

endmodule

// File: tb/tb_osc_freq_cal.sv
// Bench for osc_freq_cal: behavioural ring-osc model (400 - 20*units - lsb counts per window)
// feeding a gray counter, a table of full calibrations, and hand-written corner sequences.
module tb_osc_freq_cal;
  localparam int CNT_W   = 12;
  localparam int WIN_CYC = 64;

  logic             ref_clk = 1'b0;
  logic             rstb = 1'b0;
  logic             cal_en = 1'b0;
  logic [CNT_W-1:0] target_cnt = '0;
  logic [CNT_W-1:0] osc_cnt_gray;
  logic [7:0]       delay_con_msb;
  logic [4:0]       delay_con_lsb;
  logic             cal_busy;
  logic             locked;
  logic [CNT_W-1:0] meas_cnt;

  osc_freq_cal #(.CNT_W(CNT_W), .WIN_CYC(WIN_CYC), .TOL(2)) dut (
    .ref_clk      (ref_clk),
    .rstb         (rstb),
    .cal_en       (cal_en),
    .target_cnt   (target_cnt),
    .osc_cnt_gray (osc_cnt_gray),
    .delay_con_msb(delay_con_msb),
    .delay_con_lsb(delay_con_lsb),
    .cal_busy     (cal_busy),
    .locked       (locked),
    .meas_cnt     (meas_cnt)
  );

  always #5 ref_clk = ~ref_clk;

  // Oscillator model: accumulate rate/64 edges per ref cycle, so a window of constant codes
  // advances the counter by exactly rate.
  int          drift = 0;
  int          rate;
  logic        ovr = 1'b0;
  logic [11:0] ovr_val = '0;
  logic [17:0] acc = '0;
  logic [11:0] osc_bin;

  always_comb rate = 400 - 20 * $countones(delay_con_msb) - int'(delay_con_lsb) + drift;
  always @(posedge ref_clk) acc <= acc + 18'(rate);
  assign osc_bin      = ovr ? ovr_val : acc[17:6];
  assign osc_cnt_gray = osc_bin ^ (osc_bin >> 1);

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] target;
    logic [7:0]  peak;
    logic [7:0]  msb;
    logic [4:0]  lsb;
    logic [11:0] meas;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic start_cal(input logic [11:0] t);
    cal_en = 1'b0;
    repeat (2) @(negedge ref_clk);
    target_cnt = t;
    cal_en = 1'b1;
  endtask

  task automatic wait_lock(output bit ok, output logic [7:0] peak, output bit busy_ok);
    ok = 1'b0;
    peak = 8'h00;
    busy_ok = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge ref_clk);
      if (locked) begin
        ok = 1'b1;
        break;
      end
      if (!cal_busy) busy_ok = 1'b0;
      if (delay_con_msb > peak) peak = delay_con_msb;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          busy_ok;
    bit          hit;
    logic [7:0]  peak;
    int          lost;

    vecs[0] = '{target: 12'd350, peak: 8'h07, msb: 8'h03, lsb: 5'd10, meas: 12'd350};
    vecs[1] = '{target: 12'd250, peak: 8'hFF, msb: 8'h7F, lsb: 5'd10, meas: 12'd250};
    vecs[2] = '{target: 12'd379, peak: 8'h03, msb: 8'h01, lsb: 5'd1,  meas: 12'd379};
    vecs[3] = '{target: 12'd400, peak: 8'h00, msb: 8'h00, lsb: 5'd0,  meas: 12'd400};
    vecs[4] = '{target: 12'd228, peak: 8'hFF, msb: 8'h7F, lsb: 5'd31, meas: 12'd229};
    vecs[5] = '{target: 12'd300, peak: 8'h1F, msb: 8'h0F, lsb: 5'd20, meas: 12'd300};

    // Power-on reset values
    repeat (3) @(negedge ref_clk);
    check("rst_msb", 32'(delay_con_msb), 32'h00);
    check("rst_lsb", 32'(delay_con_lsb), 0);
    check("rst_busy", 32'(cal_busy), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_meas", 32'(meas_cnt), 0);
    rstb = 1'b1;
    @(negedge ref_clk);

    // Full calibrations from a table of targets
    for (int v = 0; v < 6; v++) begin
      start_cal(vecs[v].target);
      wait_lock(ok, peak, busy_ok);
      check("lock_reached", 32'(ok), 1);
      check("busy_in_search", 32'(busy_ok), 1);
      check("coarse_peak", 32'(peak), 32'(vecs[v].peak));
      repeat (3 * WIN_CYC) @(negedge ref_clk);
      check("final_msb", 32'(delay_con_msb), 32'(vecs[v].msb));
      check("final_lsb", 32'(delay_con_lsb), 32'(vecs[v].lsb));
      check("final_meas", 32'(meas_cnt), 32'(vecs[v].meas));
      check("final_locked", 32'(locked), 1);
      $display("vec %0d target=%0d peak=%h msb=%h lsb=%0d meas=%0d locked=%0d",
               v, vecs[v].target, peak, delay_con_msb, delay_con_lsb, meas_cnt, locked);
    end

    // Tracking: locked at target 300, osc drifts fast by 5 counts
    drift = 5;
    lost = 0;
    for (int i = 0; i < 12 * WIN_CYC; i++) begin
      @(negedge ref_clk);
      if (!locked) lost++;
    end
    check("drift_lsb", 32'(delay_con_lsb), 23);
    check("drift_meas", 32'(meas_cnt), 302);
    check("drift_lock_kept", 32'(lost), 0);
    $display("drift +5: lsb=%0d meas=%0d unlocked_cycles=%0d", delay_con_lsb, meas_cnt, lost);
    drift = 0;

    // Unreachable target: fine range exhausted, tracking forces a full recalibration
    start_cal(12'd100);
    wait_lock(ok, peak, busy_ok);
    check("sat_lock", 32'(ok), 1);
    check("sat_peak", 32'(peak), 32'hFF);
    check("sat_msb", 32'(delay_con_msb), 32'h7F);
    check("sat_lsb", 32'(delay_con_lsb), 31);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ref_clk);
      if (!locked) begin
        hit = 1'b1;
        break;
      end
    end
    check("recal_unlock", 32'(hit), 1);
    check("recal_msb", 32'(delay_con_msb), 0);
    check("recal_lsb", 32'(delay_con_lsb), 0);
    check("recal_busy", 32'(cal_busy), 1);
    $display("target 100: recal msb=%h lsb=%0d busy=%0d", delay_con_msb, delay_con_lsb, cal_busy);

    // Abort during coarse search
    start_cal(12'd300);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ref_clk);
      if (delay_con_msb == 8'h03) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reach", 32'(hit), 1);
    cal_en = 1'b0;
    @(negedge ref_clk);
    check("abort_busy", 32'(cal_busy), 0);
    check("abort_locked", 32'(locked), 0);
    check("abort_msb", 32'(delay_con_msb), 32'h03);
    check("abort_lsb", 32'(delay_con_lsb), 0);
    repeat (200) @(negedge ref_clk);
    check("abort_msb_held", 32'(delay_con_msb), 32'h03);
    check("abort_busy_held", 32'(cal_busy), 0);
    $display("abort: msb=%h busy=%0d", delay_con_msb, cal_busy);

    // Reset asserted mid-FINE for one cycle, cal_en still high
    start_cal(12'd300);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ref_clk);
      if (delay_con_lsb != 5'd0) begin
        hit = 1'b1;
        break;
      end
    end
    check("fine_reach", 32'(hit), 1);
    check("fine_busy", 32'(cal_busy), 1);
    rstb = 1'b0;
    @(negedge ref_clk);
    rstb = 1'b1;
    check("mrst_msb", 32'(delay_con_msb), 0);
    check("mrst_lsb", 32'(delay_con_lsb), 0);
    check("mrst_busy", 32'(cal_busy), 0);
    check("mrst_locked", 32'(locked), 0);
    check("mrst_meas", 32'(meas_cnt), 0);
    repeat (10) @(negedge ref_clk);
    check("mrst_idle_busy", 32'(cal_busy), 0);
    $display("mid-FINE reset: msb=%h lsb=%0d busy=%0d", delay_con_msb, delay_con_lsb, cal_busy);

    // Counter wrap: frozen count 0xFF0, then jump to 0x0A0 while tracking target 0
    cal_en = 1'b0;
    ovr_val = 12'hFF0;
    ovr = 1'b1;
    rstb = 1'b0;
    @(negedge ref_clk);
    rstb = 1'b1;
    start_cal(12'd0);
    wait_lock(ok, peak, busy_ok);
    check("wrap_lock", 32'(ok), 1);
    repeat (2 * WIN_CYC) @(negedge ref_clk);
    check("wrap_meas0", 32'(meas_cnt), 0);
    check("wrap_lsb", 32'(delay_con_lsb), 31);
    ovr_val = 12'h0A0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ref_clk);
      if (meas_cnt != '0) begin
        hit = 1'b1;
        break;
      end
    end
    check("wrap_seen", 32'(hit), 1);
    check("wrap_meas", 32'(meas_cnt), 176);
    $display("wrap: prev=0xFF0 new=0x0A0 meas=%0d", meas_cnt);
    ovr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
